// File: rtl/tag_array_sa.sv
// Set-associative tag array with true-LRU ages, fill/victim, dirty/invalidate ops and sequenced flush.
// One request per cycle, response one cycle after acceptance; requests refused while flushing or on flush_start.
module tag_array_sa #(
  parameter int  INDEX_LEN = 4,
  parameter int  TAG_LEN   = 8,
  parameter int  NUM_WAYS  = 2,
  localparam int NUM_SETS  = 2**INDEX_LEN,
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [INDEX_LEN-1:0] req_index,
  input  logic [TAG_LEN-1:0]   req_tag,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [WAY_W-1:0]     resp_way,
  output logic                 resp_dirty,
  output logic                 resp_evict,
  output logic [TAG_LEN-1:0]   resp_evict_tag,
  input  logic                 flush_start,
  output logic                 flush_busy
);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_MARK   = 2'b10;
  localparam logic [1:0] OP_INV    = 2'b11;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t               state_q;
  logic [INDEX_LEN-1:0] flush_cnt_q;

  logic [TAG_LEN-1:0]  tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [WAY_W-1:0]    age_q   [NUM_SETS][NUM_WAYS];

  logic             accept;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] tgt_way;
  logic [WAY_W-1:0] touch_age;
  logic             do_touch;
  logic             evict;

  assign req_ready = (state_q == IDLE) && !flush_start;
  assign accept    = req_valid && req_ready;

  // Victim: lowest invalid way first, otherwise the way holding the oldest age.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_index][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (age_q[req_index][w] == WAY_W'(NUM_WAYS - 1))
        lru_way = WAY_W'(w);
    end
    victim    = inv_found ? inv_way : lru_way;
    tgt_way   = hit ? hit_way : victim;
    touch_age = age_q[req_index][tgt_way];
    do_touch  = accept && ((req_op == OP_FILL) ||
                           (hit && ((req_op == OP_LOOKUP) || (req_op == OP_MARK))));
    evict     = (req_op == OP_FILL) && !hit &&
                valid_q[req_index][victim] && dirty_q[req_index][victim];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
      flush_busy  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (flush_start) begin
          state_q     <= FLUSH;
          flush_cnt_q <= '0;
          flush_busy  <= 1'b1;
        end
        FLUSH: if (flush_cnt_q == INDEX_LEN'(NUM_SETS - 1)) begin
          state_q    <= IDLE;
          flush_busy <= 1'b0;
        end else begin
          flush_cnt_q <= flush_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
      end
    end else if (state_q == FLUSH) begin
      valid_q[flush_cnt_q] <= '0;
      dirty_q[flush_cnt_q] <= '0;
      for (int w = 0; w < NUM_WAYS; w++)
        age_q[flush_cnt_q][w] <= WAY_W'(w);
    end else if (accept) begin
      case (req_op)
        OP_FILL: begin
          valid_q[req_index][tgt_way] <= 1'b1;
          dirty_q[req_index][tgt_way] <= 1'b0;
        end
        OP_MARK: if (hit) dirty_q[req_index][hit_way] <= 1'b1;
        OP_INV: if (hit) begin
          valid_q[req_index][hit_way] <= 1'b0;
          dirty_q[req_index][hit_way] <= 1'b0;
        end
        default: ;
      endcase
      if (do_touch) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (WAY_W'(w) == tgt_way)
            age_q[req_index][w] <= '0;
          else if (age_q[req_index][w] < touch_age)
            age_q[req_index][w] <= age_q[req_index][w] + 1'b1;
        end
      end
    end
  end

  // Tag contents need no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (accept && (req_op == OP_FILL) && !hit)
      tag_q[req_index][victim] <= req_tag;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      resp_valid     <= 1'b0;
      resp_hit       <= 1'b0;
      resp_way       <= '0;
      resp_dirty     <= 1'b0;
      resp_evict     <= 1'b0;
      resp_evict_tag <= '0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_hit       <= hit;
        resp_way       <= hit ? hit_way : ((req_op == OP_FILL) ? victim : '0);
        resp_dirty     <= hit && dirty_q[req_index][hit_way];
        resp_evict     <= evict;
        resp_evict_tag <= evict ? tag_q[req_index][victim] : '0;
      end
    end
  end

endmodule

// File: tb/tb_tag_array_sa.sv
// Directed and randomized checks of tag_array_sa against a recency-list reference model.
module tb_tag_array_sa;
  localparam int INDEX_LEN = 4;
  localparam int TAG_LEN   = 8;
  localparam int NUM_WAYS  = 2;
  localparam int NUM_SETS  = 2**INDEX_LEN;
  localparam int WAY_W     = 1;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [1:0]           req_op = 2'b00;
  logic [INDEX_LEN-1:0] req_index = '0;
  logic [TAG_LEN-1:0]   req_tag = '0;
  logic                 resp_valid, resp_hit, resp_dirty, resp_evict;
  logic [WAY_W-1:0]     resp_way;
  logic [TAG_LEN-1:0]   resp_evict_tag;
  logic                 flush_start = 1'b0;
  logic                 flush_busy;

  int vectors = 0;
  int miscompares = 0;

  tag_array_sa #(.INDEX_LEN(INDEX_LEN), .TAG_LEN(TAG_LEN), .NUM_WAYS(NUM_WAYS)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_index(req_index), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .resp_dirty(resp_dirty), .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
    .flush_start(flush_start), .flush_busy(flush_busy)
  );

  always #5 clk = ~clk;

  // Reference: per-way contents plus a recency list (front = most recent).
  bit               m_valid [NUM_SETS][NUM_WAYS];
  bit               m_dirty [NUM_SETS][NUM_WAYS];
  logic [TAG_LEN-1:0] m_tag [NUM_SETS][NUM_WAYS];
  int               m_lru   [NUM_SETS][$];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      m_lru[s].delete();
      for (int w = 0; w < NUM_WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
        m_lru[s].push_back(w);
      end
    end
  endtask

  task automatic touch(input int s, input int w);
    for (int p = 0; p < m_lru[s].size(); p++)
      if (m_lru[s][p] == w) begin
        m_lru[s].delete(p);
        break;
      end
    m_lru[s].push_front(w);
  endtask

  task automatic model_op(input logic [1:0] op, input int s, input logic [TAG_LEN-1:0] t,
                          output logic e_hit, output logic [WAY_W-1:0] e_way,
                          output logic e_dirty, output logic e_evict,
                          output logic [TAG_LEN-1:0] e_etag);
    int hw = -1;
    int v = -1;
    for (int w = 0; w < NUM_WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    e_hit = (hw >= 0);
    e_way = '0; e_dirty = 1'b0; e_evict = 1'b0; e_etag = '0;
    if (e_hit) begin
      e_way   = WAY_W'(hw);
      e_dirty = m_dirty[s][hw];
    end
    case (op)
      2'b00: if (e_hit) touch(s, hw);
      2'b01: begin
        if (e_hit) begin
          m_dirty[s][hw] = 0;
          touch(s, hw);
        end else begin
          for (int w = 0; w < NUM_WAYS; w++)
            if (!m_valid[s][w] && v < 0) v = w;
          if (v < 0) v = m_lru[s][m_lru[s].size() - 1];
          e_way   = WAY_W'(v);
          e_evict = m_valid[s][v] && m_dirty[s][v];
          e_etag  = e_evict ? m_tag[s][v] : '0;
          m_tag[s][v]   = t;
          m_valid[s][v] = 1;
          m_dirty[s][v] = 0;
          touch(s, v);
        end
      end
      2'b10: if (e_hit) begin
        m_dirty[s][hw] = 1;
        touch(s, hw);
      end
      default: if (e_hit) begin
        m_valid[s][hw] = 0;
        m_dirty[s][hw] = 0;
      end
    endcase
  endtask

  // Called at a falling edge; returns at the next falling edge with the response visible.
  task automatic issue(input logic [1:0] op, input int s, input logic [TAG_LEN-1:0] t);
    logic eh, ed, ee;
    logic [WAY_W-1:0] ew;
    logic [TAG_LEN-1:0] et;
    check("req_ready", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_index = INDEX_LEN'(s); req_tag = t;
    model_op(op, s, t, eh, ew, ed, ee, et);
    @(negedge clk);
    check("resp_valid", resp_valid, 1);
    check("resp_hit", resp_hit, eh);
    check("resp_way", resp_way, ew);
    check("resp_dirty", resp_dirty, ed);
    check("resp_evict", resp_evict, ee);
    check("resp_evict_tag", resp_evict_tag, et);
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_way", resp_way, 0);
    check("rst_resp_dirty", resp_dirty, 0);
    check("rst_resp_evict", resp_evict, 0);
    check("rst_evict_tag", resp_evict_tag, 0);
    check("rst_flush_busy", flush_busy, 0);
    check("rst_req_ready", req_ready, 1);
    resetn = 1'b1;
    @(negedge clk);

    // Basic miss / fill / hit
    issue(2'b00, 5, 8'h12); check("first_lookup_hit", resp_hit, 0);
    issue(2'b01, 5, 8'h12); check("fill_way", resp_way, 0); check("fill_evict", resp_evict, 0);
    issue(2'b00, 5, 8'h12); check("relookup_hit", resp_hit, 1);
    idle(); @(negedge clk);
    check("resp_one_cycle", resp_valid, 0);

    // LRU eviction of a dirty line
    issue(2'b01, 3, 8'h21);
    issue(2'b01, 3, 8'h34);
    issue(2'b10, 3, 8'h21);
    issue(2'b00, 3, 8'h34);
    issue(2'b01, 3, 8'h56);
    check("lru_victim_way", resp_way, 0);
    check("lru_evict", resp_evict, 1);
    check("lru_evict_tag", resp_evict_tag, 8'h21);
    issue(2'b00, 3, 8'h21); check("evicted_lookup", resp_hit, 0);

    // Duplicate fill reuses the way
    issue(2'b01, 0, 8'h07);
    issue(2'b01, 0, 8'h07);
    check("dup_way", resp_way, 0); check("dup_hit", resp_hit, 1); check("dup_evict", resp_evict, 0);
    issue(2'b01, 0, 8'h08); check("second_fill_way", resp_way, 1);

    // Back-to-back same-set visibility
    issue(2'b01, 9, 8'h44);
    issue(2'b00, 9, 8'h44); check("b2b_hit", resp_hit, 1);
    issue(2'b11, 9, 8'h44);
    issue(2'b00, 9, 8'h44); check("inv_then_miss", resp_hit, 0);

    // Randomized traffic on a few sets with a small tag pool to force hits and evictions
    for (int i = 0; i < 300; i++)
      issue(2'($urandom_range(3)), $urandom_range(3), 8'($urandom_range(5)));
    idle(); @(negedge clk);

    // Flush: fill four sets, start flush with a competing request
    for (int s = 10; s < 14; s++) issue(2'b01, s, 8'(8'h90 + s));
    flush_start = 1'b1; req_valid = 1'b1; req_op = 2'b00; req_index = 4'd10; req_tag = 8'h9a;
    #1 check("flush_refuses_req", req_ready, 0);
    @(negedge clk);
    flush_start = 1'b0; req_valid = 1'b0;
    check("refused_no_resp", resp_valid, 0);
    model_reset();
    cyc = 0;
    while (flush_busy === 1'b1 && cyc < 100) begin
      cyc++;
      flush_start = (cyc == 3);
      @(negedge clk);
    end
    flush_start = 1'b0;
    check("flush_busy_cycles", cyc, NUM_SETS);
    check("ready_after_flush", req_ready, 1);
    for (int s = 10; s < 14; s++) begin
      issue(2'b00, s, 8'(8'h90 + s));
      check("post_flush_miss", resp_hit, 0);
    end
    idle(); @(negedge clk);

    // Reset asserted while flushing set 2
    flush_start = 1'b1;
    @(negedge clk);
    flush_start = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_mid_flush", flush_busy, 1);
    resetn = 1'b0;
    #1;
    check("rst_mid_flush_busy", flush_busy, 0);
    check("rst_mid_flush_ready", req_ready, 1);
    check("rst_mid_flush_resp", resp_valid, 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 4; s++)
      for (int t = 0; t < 6; t++) begin
        issue(2'b00, s, 8'(t));
        check("post_reset_miss", resp_hit, 0);
      end
    issue(2'b01, 7, 8'h11); check("order_w0", resp_way, 0);
    issue(2'b01, 7, 8'h22); check("order_w1", resp_way, 1);
    issue(2'b01, 7, 8'h33); check("order_lru", resp_way, 0);
    idle(); @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
